mux_arbiter: RTL

- Round-robin arbiter that shares the 3-input, 32-bit datapath mux among three requesters.
- Drives the mux select (mux_ctrl) and a valid/ready handshake toward the downstream consumer.
- Returns a per-requester ack for every beat accepted.
- Bursts are bounded by requester-marked last beats and a maximum burst length.

---
 rtl/mux_arbiter_pkg.sv | 46 ++++
 rtl/mux_arbiter_if.sv | 32 +++
 rtl/mux_arbiter_rr_pick3.sv | 41 ++++
 rtl/mux_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mux_arbiter_pkg.sv
// ============================================================================
// Module : mux_arbiter_pkg
// Brief  : Shared widths, state encoding and select helpers for the arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mux_arbiter_pkg;

    localparam int N_REQ = 3;
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] SEL_IN0 = 2'd0;
    localparam logic [SEL_W-1:0] SEL_IN1 = 2'd1;
    localparam logic [SEL_W-1:0] SEL_IN2 = 2'd2;

    function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [N_REQ-1:0] oh;
        case (sel)
            SEL_IN0: oh = 3'b001;
            SEL_IN1: oh = 3'b010;
            SEL_IN2: oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Round-robin successor, wrapping 2 -> 0.
    function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] sel);
        logic [SEL_W-1:0] nxt;
        case (sel)
            SEL_IN0: nxt = SEL_IN1;
            SEL_IN1: nxt = SEL_IN2;
            default: nxt = SEL_IN0;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_arbiter_if.sv
// ============================================================================
// Module : mux_arbiter_if
// Brief  : Request/grant/handshake bundle between requesters, arbiter and sink.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface mux_arbiter_if;
    import mux_arbiter_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] last;
    logic             out_ready;
    logic [SEL_W-1:0] mux_ctrl;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] ack;
    logic             out_valid;
    logic             busy;

    modport master (
        input  req, last, out_ready,
        output mux_ctrl, grant, ack, out_valid, busy
    );

    modport slave (
        output req, last, out_ready,
        input  mux_ctrl, grant, ack, out_valid, busy
    );

endinterface

`default_nettype wire

// File: rtl/mux_arbiter_rr_pick3.sv
// ============================================================================
// Module : rr_pick3
// Brief  : Combinational 3-way rotating-priority picker starting at ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_pick3
    import mux_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             found
);

    always_comb begin
        winner = SEL_IN0;
        found  = |req;
        case (ptr)
            SEL_IN1: begin
                if      (req[1]) winner = SEL_IN1;
                else if (req[2]) winner = SEL_IN2;
                else if (req[0]) winner = SEL_IN0;
            end
            SEL_IN2: begin
                if      (req[2]) winner = SEL_IN2;
                else if (req[0]) winner = SEL_IN0;
                else if (req[1]) winner = SEL_IN1;
            end
            default: begin
                if      (req[0]) winner = SEL_IN0;
                else if (req[1]) winner = SEL_IN1;
                else if (req[2]) winner = SEL_IN2;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mux_arbiter.sv
// ============================================================================
// Module : mux_arbiter
// Brief  : Round-robin arbiter driving a 3-input mux select with burst control.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
)(
    input  logic         clk,
    input  logic         rst,
    mux_arbiter_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t           r_state;
    logic [N_REQ-1:0] r_grant;
    logic [SEL_W-1:0] r_mux_ctrl;
    logic [SEL_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_beat_cnt;

    state_t           w_state_nxt;
    logic [N_REQ-1:0] w_grant_nxt;
    logic [SEL_W-1:0] w_mux_nxt;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [SEL_W-1:0] w_winner;
    logic             w_found;
    logic             w_sel_req;
    logic             w_sel_last;
    logic             w_out_valid;
    logic             w_xfer;
    logic [N_REQ-1:0] w_ack;

    rr_pick3 u_pick (
        .req    (bus.req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .found  (w_found)
    );

    always_comb begin
        w_sel_req  = 1'b0;
        w_sel_last = 1'b0;
        case (r_mux_ctrl)
            SEL_IN0: begin w_sel_req = bus.req[0]; w_sel_last = bus.last[0]; end
            SEL_IN1: begin w_sel_req = bus.req[1]; w_sel_last = bus.last[1]; end
            SEL_IN2: begin w_sel_req = bus.req[2]; w_sel_last = bus.last[2]; end
            default: begin w_sel_req = 1'b0;       w_sel_last = 1'b0;       end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_mux_ctrl <= SEL_IN0;
            r_ptr      <= SEL_IN0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_mux_ctrl <= w_mux_nxt;
            r_ptr      <= w_ptr_nxt;
            r_beat_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_mux_nxt   = r_mux_ctrl;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_beat_cnt;
        w_out_valid = 1'b0;
        w_xfer      = 1'b0;
        w_ack       = '0;
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = '0;
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = sel_onehot(w_winner);
                    w_mux_nxt   = w_winner;
                    w_cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                // A beat caught by reset is never acknowledged.
                w_out_valid = w_sel_req & ~rst;
                w_xfer      = w_out_valid & bus.out_ready;
                w_ack       = w_xfer ? sel_onehot(r_mux_ctrl) : '0;
                if (!w_sel_req || (w_xfer && (w_sel_last || r_beat_cnt == CNT_LAST))) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = sel_next(r_mux_ctrl);
                    w_cnt_nxt   = '0;
                end else if (w_xfer) begin
                    w_cnt_nxt = r_beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    assign bus.mux_ctrl  = r_mux_ctrl;
    assign bus.grant     = r_grant;
    assign bus.ack       = w_ack;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = (r_state == ST_GRANT);

endmodule

`default_nettype wire
